// File: rtl/cdc_word_sender.sv
// cdc_word_sender: source-domain half of a toggle req/ack word-transfer CDC channel.
// A word accepted on s_valid/s_ready is held on data_out while req_tgl is
// toggled. The far domain answers by toggling ack_tgl. That toggle is brought
// back through a SYNC_STAGES flop chain, and its arrival completes the transfer.
// Only one transfer is in flight at a time.
//
// Ports:
//   src_clk, src_rst_n   source clock, async active-low reset
//   s_data/s_valid/s_ready  word input handshake (s_ready = idle)
//   data_out             held word, stable while req_tgl != synchronized ack
//   req_tgl              registered request toggle to far domain
//   ack_tgl              asynchronous ack toggle from far domain
//   done                 one-cycle completion pulse
//   err_clr              clears sticky errors (a same-edge set wins)
//   err_timeout          sticky: WAIT lasted TIMEOUT cycles (0 disables)
//   err_proto            sticky: ack toggled with no request outstanding
module cdc_word_sender #(
  parameter int   WIDTH       = 32,
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMEOUT     = 1024,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_tgl,
  input  logic             ack_tgl,
  output logic             done,
  input  logic             err_clr,
  output logic             err_timeout,
  output logic             err_proto
);

  localparam int TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]       r_data;
  logic                   r_req;
  logic                   r_done;
  logic [TW-1:0]          r_timer;
  logic                   r_err_to;
  logic                   r_err_p;

  logic          w_ack_s;
  logic          w_accept;
  logic          w_complete;
  logic          w_proto_set;
  logic          w_to_set;
  logic [TW-1:0] w_timer_nxt;

  // ack_tgl is asynchronous. Nothing except the first flop of this chain samples it.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) r_sync <= '0;
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_tgl};
  end
  assign w_ack_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_proto_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The synchronized ack should equal req while idle. A mismatch means
        // the far side toggled on its own.
        w_proto_set = (w_ack_s != r_req);
        w_accept    = s_valid;
        if (s_valid) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_ack_s == r_req) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The timer saturates at TMAX. Reaching TMAX only flags an error; waiting continues.
  always_comb begin
    w_timer_nxt = r_timer;
    w_to_set    = 1'b0;
    if (TIMEOUT != 0 && r_state == ST_WAIT) begin
      if (r_timer != TMAX) w_timer_nxt = r_timer + TW'(1);
      w_to_set = (w_timer_nxt == TMAX);
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_data   <= {WIDTH{RST_VAL}};
      r_req    <= 1'b0;
      r_done   <= 1'b0;
      r_timer  <= '0;
      r_err_to <= 1'b0;
      r_err_p  <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_accept) begin
        r_data  <= s_data;
        r_req   <= ~r_req;
        r_timer <= '0;
      end else begin
        r_timer <= w_timer_nxt;
      end
      if (w_to_set)     r_err_to <= 1'b1;
      else if (err_clr) r_err_to <= 1'b0;
      if (w_proto_set)  r_err_p  <= 1'b1;
      else if (err_clr) r_err_p  <= 1'b0;
    end
  end

  assign s_ready     = (r_state == ST_IDLE);
  assign data_out    = r_data;
  assign req_tgl     = r_req;
  assign done        = r_done;
  assign err_timeout = r_err_to;
  assign err_proto   = r_err_p;

endmodule

// File: doc/cdc_word_sender.md
Name: cdc_word_sender

Overview:
- Source-clock-domain half of a toggle req/ack word-transfer CDC channel.
- Accepts a word on a valid/ready interface and holds it stable on a data bus for the far domain.
- Toggles a request line, then waits for the far domain's acknowledge toggle, which this block brings back through an internal synchronizer chain.
- Pairs with a destination-side receiver built on the team's two-flop synchronizer; one transfer in flight at a time.

Parameters:
- WIDTH, 32, data word width.
- SYNC_STAGES, 2, flops in the ack synchronizer chain; legal range 2..4.
- TIMEOUT, 1024, cycles in WAIT before the timeout error sets; 0 disables the timer.
- RST_VAL, 1'b0, bit value replicated into data_out on reset.

Ports:
- src_clk  in  1  source clock; the only clock.
- src_rst_n  in  1  asynchronous active-low reset.
- s_data  in  WIDTH  word to send.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept a word.
- data_out  out  WIDTH  held word to far domain; stable whenever req_tgl differs from ack.
- req_tgl  out  1  request toggle to far domain, registered.
- ack_tgl  in  1  asynchronous ack toggle from far domain.
- done  out  1  one-cycle pulse when a transfer completes.
- err_clr  in  1  clears sticky error flags.
- err_timeout  out  1  sticky: WAIT exceeded TIMEOUT cycles.
- err_proto  out  1  sticky: ack toggled while no request outstanding.

Behaviour:
- Reset (async assert, release synchronous to src_clk):
  - state=IDLE, req_tgl=0, data_out={WIDTH{RST_VAL}}, sync chain=0.
  - done=0, both errors=0, timer=0.
- s_ready = (state==IDLE). It is combinational from the state register only, with no combinational path from s_valid.
- Synchronizer: ack_tgl feeds SYNC_STAGES flops; ack_s is the last stage. No other logic samples ack_tgl.
- IDLE:
  - On s_valid&&s_ready at edge E: data_out<=s_data, req_tgl<=~req_tgl, state<=WAIT, timer<=0.
  - Both outputs update after E; s_ready is low from E on.
- WAIT:
  - data_out holds. s_valid is ignored and s_ready stays low.
  - When ack_s==req_tgl at an edge: state<=IDLE, done<=1 for exactly one cycle.
  - If ack_tgl flips before edge A, s_ready and done rise after edge A+SYNC_STAGES.
  - A new word may be accepted on the cycle s_ready is high, so back-to-back transfers are possible.
- Timer:
  - In WAIT with TIMEOUT!=0, the timer increments every cycle and saturates at TIMEOUT.
  - On reaching TIMEOUT, err_timeout<=1.
  - The block keeps waiting; there is no retry and no abort. A late ack still completes normally.
- Protocol error: in IDLE, ack_s!=req_tgl sets err_proto<=1. The state does not change and no done pulse is produced.
- err_clr:
  - Clears both errors on the next edge.
  - If a set condition and err_clr occur on the same edge, set wins.
- Reset mid-WAIT: returns to IDLE with req_tgl=0. The far side must be reset in the same event; otherwise err_proto may set, which is the intended signalling.
- Counter widths: timer is $clog2(TIMEOUT+1) bits, minimum 1.

Test Plan:
- Basic transfer (SYNC_STAGES=2):
  - Stimulus: send 0xDEADBEEF at edge 0; the bench flips ack_tgl before edge 5.
  - Required: req_tgl=1 and data_out=0xDEADBEEF after edge 0; s_ready=0 for edges 1..6; done=1 and s_ready=1 after edge 7 only.
- Back-to-back:
  - Stimulus: s_valid held high with 0x1, then 0x2; the bench acks each 3 cycles after its req edge.
  - Required: two done pulses; req_tgl goes 0→1→0; data_out=0x2 only after 0x1 is acked; 0x2 is accepted on the same cycle s_ready rises.
- Timeout:
  - Stimulus: TIMEOUT=8; send a word and never ack.
  - Required: err_timeout=1 after 8 WAIT cycles, data_out still held. A later ack gives done=1 with err_timeout staying 1; err_clr then clears it.
- Protocol error:
  - Stimulus: in IDLE, flip ack_tgl.
  - Required: err_proto=1 two cycles later, state IDLE, no done. err_clr asserted on the same edge as a fresh set leaves err_proto=1.
- Reset mid-transfer:
  - Stimulus: assert src_rst_n=0 asynchronously during WAIT.
  - Required: req_tgl=0, data_out=RST_VAL fill, s_ready=1 immediately (without waiting for a clock edge); no done pulse.
- Ready stability: vary s_valid randomly during WAIT -> s_ready stays 0, data_out unchanged, req_tgl unchanged.
